// File: rtl/neopixel_strand_receiver_if.sv
// Purpose: bundles the serial line and decoded pixel/frame outputs of the strand receiver.
// Latency: none, wiring only.
// Backpressure: none; every output is a pulse or held status, and the consumer must keep up.
interface neopixel_strand_receiver_if #(
   parameter int NUM_PIXELS = 5
);
   localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int FP_W  = (NUM_PIXELS > 0) ? $clog2(NUM_PIXELS + 1) : 1;

   logic              neo_in;
   logic [23:0]       pixel_data;
   logic [IDX_W-1:0]  pixel_index;
   logic              pixel_valid;
   logic              frame_done;
   logic [FP_W-1:0]   frame_pixels;
   logic              frame_overflow;
   logic              frame_partial;
   logic              bit_error;

   // receiver side: takes the line, drives decoded results
   modport master (
      input  neo_in,
      output pixel_data,
      output pixel_index,
      output pixel_valid,
      output frame_done,
      output frame_pixels,
      output frame_overflow,
      output frame_partial,
      output bit_error
   );

   // line driver / result consumer side
   modport slave (
      output neo_in,
      input  pixel_data,
      input  pixel_index,
      input  pixel_valid,
      input  frame_done,
      input  frame_pixels,
      input  frame_overflow,
      input  frame_partial,
      input  bit_error
   );
endinterface

// File: rtl/neopixel_strand_receiver.sv
// Purpose: decodes a single-wire NeoPixel strand into 24-bit pixel words plus end-of-frame status.
// Latency: pixel_valid / frame_done are 3 edges after the deciding neo_in sample (2 sync + 1 register).
// Backpressure: none; results are one-cycle pulses or status held until the next frame_done.
module neopixel_strand_receiver #(
   parameter int NUM_PIXELS    = 5,
   parameter int ONE_THRESHOLD = 27,
   parameter int MIN_HIGH      = 8,
   parameter int MAX_HIGH      = 60,
   parameter int LATCH_CYCLES  = 1000
) (
   input logic                        clock,
   input logic                        reset_n,
   neopixel_strand_receiver_if.master bus
);
   localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int FP_W  = (NUM_PIXELS > 0) ? $clog2(NUM_PIXELS + 1) : 1;
   localparam int WC_W  = $clog2(NUM_PIXELS + 2);
   localparam int LC_W  = $clog2(LATCH_CYCLES + 1);

   localparam logic [WC_W-1:0] WC_FULL = WC_W'(NUM_PIXELS);
   localparam logic [WC_W-1:0] WC_SAT  = WC_W'(NUM_PIXELS + 1);
   localparam logic [FP_W-1:0] FP_FULL = FP_W'(NUM_PIXELS);
   localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATCH_CYCLES - 1);
   localparam logic [6:0]      HC_ONE  = 7'(ONE_THRESHOLD);
   localparam logic [6:0]      HC_MIN  = 7'(MIN_HIGH);
   localparam logic [6:0]      HC_MAX  = 7'(MAX_HIGH);

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_LOW  = 2'd3;

   logic              neo_meta;
   logic              neo_s;
   logic              neo_d;
   logic              rise;

   logic [1:0]        state;
   logic [6:0]        high_cnt;
   logic [LC_W-1:0]   low_cnt;
   logic [4:0]        bit_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [23:0]       shift_reg;
   logic              ovf_flag;
   logic              new_bit;
   logic [23:0]       shifted;

   logic [23:0]       pixel_data_r;
   logic [IDX_W-1:0]  pixel_index_r;
   logic              pixel_valid_r;
   logic              frame_done_r;
   logic [FP_W-1:0]   frame_pixels_r;
   logic              frame_overflow_r;
   logic              frame_partial_r;
   logic              bit_error_r;

   assign rise    = neo_s & ~neo_d;
   assign new_bit = (high_cnt > HC_ONE);
   // LSB-first: each new bit enters at the top and walks down to bit 0
   assign shifted = {new_bit, shift_reg[23:1]};

   // two-flop synchronizer for the asynchronous line, plus one delay for edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         neo_meta <= 1'b0;
         neo_s    <= 1'b0;
         neo_d    <= 1'b0;
      end else begin
         neo_meta <= bus.neo_in;
         neo_s    <= neo_meta;
         neo_d    <= neo_s;
      end
   end

   // pulse-width decoder FSM with word assembly and frame status capture
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_SYNC;
         high_cnt         <= '0;
         low_cnt          <= '0;
         bit_cnt          <= '0;
         word_cnt         <= '0;
         shift_reg        <= '0;
         ovf_flag         <= 1'b0;
         pixel_data_r     <= '0;
         pixel_index_r    <= '0;
         pixel_valid_r    <= 1'b0;
         frame_done_r     <= 1'b0;
         frame_pixels_r   <= '0;
         frame_overflow_r <= 1'b0;
         frame_partial_r  <= 1'b0;
         bit_error_r      <= 1'b0;
      end else begin
         pixel_valid_r <= 1'b0;
         frame_done_r  <= 1'b0;
         bit_error_r   <= 1'b0;
         case (state)
            ST_SYNC: begin
               // wait out a full latch interval of low so a truncated frame is never decoded
               if (neo_s) begin
                  low_cnt <= '0;
               end else if (low_cnt == LC_LAST) begin
                  low_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               bit_cnt   <= '0;
               word_cnt  <= '0;
               shift_reg <= '0;
               ovf_flag  <= 1'b0;
               if (rise) begin
                  high_cnt <= 7'd1;
                  state    <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (neo_s) begin
                  // the increment would push the width past the legal maximum
                  if (high_cnt >= HC_MAX) begin
                     bit_error_r <= 1'b1;
                     bit_cnt     <= '0;
                     low_cnt     <= '0;
                     state       <= ST_SYNC;
                  end else if (high_cnt != 7'h7f) begin
                     high_cnt <= high_cnt + 7'd1;
                  end
               end else if (high_cnt < HC_MIN) begin
                  bit_error_r <= 1'b1;
                  bit_cnt     <= '0;
                  low_cnt     <= '0;
                  state       <= ST_SYNC;
               end else begin
                  shift_reg <= shifted;
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     if (word_cnt < WC_FULL) begin
                        pixel_data_r  <= shifted;
                        pixel_index_r <= word_cnt[IDX_W-1:0];
                        pixel_valid_r <= 1'b1;
                     end else begin
                        ovf_flag <= 1'b1;
                     end
                     if (word_cnt != WC_SAT) begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
                  low_cnt <= LC_W'(1);
                  state   <= ST_LOW;
               end
            end
            default: begin
               // ST_LOW: any low shorter than the latch interval keeps the frame going
               if (neo_s) begin
                  high_cnt <= 7'd1;
                  state    <= ST_HIGH;
               end else if (low_cnt == LC_LAST) begin
                  frame_done_r     <= 1'b1;
                  frame_pixels_r   <= (word_cnt > WC_FULL) ? FP_FULL : word_cnt[FP_W-1:0];
                  frame_overflow_r <= ovf_flag;
                  frame_partial_r  <= (bit_cnt != 5'd0);
                  state            <= ST_IDLE;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.pixel_data     = pixel_data_r;
   assign bus.pixel_index    = pixel_index_r;
   assign bus.pixel_valid    = pixel_valid_r;
   assign bus.frame_done     = frame_done_r;
   assign bus.frame_pixels   = frame_pixels_r;
   assign bus.frame_overflow = frame_overflow_r;
   assign bus.frame_partial  = frame_partial_r;
   assign bus.bit_error      = bit_error_r;
endmodule

// File: tb/tb_neopixel_strand_receiver.sv
// Purpose: self-checking bench for neopixel_strand_receiver using a scoreboard of expected events.
// Latency: expected events are queued as stimulus is driven and matched when the outputs pulse.
// Backpressure: none; the monitor consumes every pulse in the cycle it appears.
module tb_neopixel_strand_receiver;
   localparam int NP = 5;
   localparam int K_PIX   = 1;
   localparam int K_FRAME = 2;
   localparam int K_ERR   = 3;

   typedef struct {
      int          kind;
      logic [23:0] data;
      int          idx;
      int          fp;
      bit          ovf;
      bit          part;
   } ev_t;

   typedef struct {
      int hw;
      bit err;
      bit b;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   ev_t  mon_e;
   vec_t vecs[6];
   logic [23:0] base_w;
   logic [23:0] exp_w;
   logic [23:0] rst_w;

   always #10 clock = ~clock;

   neopixel_strand_receiver_if #(.NUM_PIXELS(NP)) bus ();

   neopixel_strand_receiver #(
      .NUM_PIXELS(NP), .ONE_THRESHOLD(27), .MIN_HIGH(8), .MAX_HIGH(60), .LATCH_CYCLES(1000)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   function automatic void push_pix(input logic [23:0] d, input int i);
      ev_t e;
      e = '{kind: K_PIX, data: d, idx: i, fp: 0, ovf: 1'b0, part: 1'b0};
      exp_q.push_back(e);
   endfunction

   function automatic void push_frame(input int fp, input bit ovf, input bit part);
      ev_t e;
      e = '{kind: K_FRAME, data: 24'h0, idx: 0, fp: fp, ovf: ovf, part: part};
      exp_q.push_back(e);
   endfunction

   function automatic void push_err();
      ev_t e;
      e = '{kind: K_ERR, data: 24'h0, idx: 0, fp: 0, ovf: 1'b0, part: 1'b0};
      exp_q.push_back(e);
   endfunction

   // all drive tasks are entered and left on a falling clock edge
   task automatic send_bit(input int hw, input int lw);
      bus.neo_in = 1'b1;
      repeat (hw) @(negedge clock);
      bus.neo_in = 1'b0;
      repeat (lw) @(negedge clock);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int j = 0; j < 24; j++) begin
         if (w[j]) send_bit(36, 30);
         else      send_bit(19, 40);
      end
   endtask

   task automatic idle_low(input int n);
      bus.neo_in = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic check_zero(input string name);
      logic [34:0] act;
      act = {bus.pixel_data, bus.pixel_index, bus.pixel_valid, bus.frame_done,
             bus.frame_pixels, bus.frame_overflow, bus.frame_partial, bus.bit_error};
      checks++;
      if (act !== 35'h0) begin
         errors++;
         $display("FAIL %s: outputs %h, required all zero", name, act);
      end
   endtask

   task automatic check_held(input string name, input int fp, input bit ovf, input bit part);
      checks++;
      if (int'(bus.frame_pixels) != fp || bus.frame_overflow !== ovf || bus.frame_partial !== part) begin
         errors++;
         $display("FAIL %s: frame_pixels %0d ovf %b partial %b, required %0d %b %b",
                  name, bus.frame_pixels, bus.frame_overflow, bus.frame_partial, fp, ovf, part);
      end
   endtask

   // scoreboard: every output pulse must match the oldest outstanding expected event
   always @(posedge clock) begin
      #1;
      if (reset_n) begin
         if (bus.pixel_valid) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_PIX) begin
               errors++;
               $display("FAIL pixel_valid: unexpected pulse data %h index %0d", bus.pixel_data, bus.pixel_index);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.pixel_data !== mon_e.data || int'(bus.pixel_index) != mon_e.idx) begin
                  errors++;
                  $display("FAIL pixel_word: data %h index %0d, required %h index %0d",
                           bus.pixel_data, bus.pixel_index, mon_e.data, mon_e.idx);
               end
            end
         end
         if (bus.frame_done) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_FRAME) begin
               errors++;
               $display("FAIL frame_done: unexpected pulse, pixels %0d ovf %b partial %b",
                        bus.frame_pixels, bus.frame_overflow, bus.frame_partial);
            end else begin
               mon_e = exp_q.pop_front();
               if (int'(bus.frame_pixels) != mon_e.fp || bus.frame_overflow !== mon_e.ovf ||
                   bus.frame_partial !== mon_e.part) begin
                  errors++;
                  $display("FAIL frame_status: pixels %0d ovf %b partial %b, required %0d %b %b",
                           bus.frame_pixels, bus.frame_overflow, bus.frame_partial,
                           mon_e.fp, mon_e.ovf, mon_e.part);
               end
            end
         end
         if (bus.bit_error) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_ERR) begin
               errors++;
               $display("FAIL bit_error: unexpected pulse, %0d events outstanding", exp_q.size());
            end else begin
               mon_e = exp_q.pop_front();
            end
         end
      end
   end

   initial begin
      #(120000 * 20);
      $display("FAIL watchdog: simulation did not finish, %0d events outstanding", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{hw: 27, err: 1'b0, b: 1'b0};
      vecs[1] = '{hw: 28, err: 1'b0, b: 1'b1};
      vecs[2] = '{hw: 8,  err: 1'b0, b: 1'b0};
      vecs[3] = '{hw: 60, err: 1'b0, b: 1'b1};
      vecs[4] = '{hw: 7,  err: 1'b1, b: 1'b0};
      vecs[5] = '{hw: 61, err: 1'b1, b: 1'b0};
      base_w = 24'hC3A50F;
      rst_w  = 24'h3C3C3C;

      bus.neo_in = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("reset_state");
      reset_n = 1'b1;
      idle_low(1010);

      // single word
      push_pix(24'h12AB34, 0);
      push_frame(1, 1'b0, 1'b0);
      send_word(24'h12AB34);
      idle_low(1010);
      check_held("single_held", 1, 1'b0, 1'b0);

      // full frame
      for (int k = 0; k < NP; k++) push_pix(24'(k + 1), k);
      push_frame(NP, 1'b0, 1'b0);
      for (int k = 0; k < NP; k++) send_word(24'(k + 1));
      idle_low(1010);
      check_held("full_held", NP, 1'b0, 1'b0);

      // pulse-width table: bit 5 of the word uses the width under test
      for (int i = 0; i < 6; i++) begin
         exp_w = base_w;
         exp_w[5] = vecs[i].b;
         if (vecs[i].err) begin
            push_err();
         end else begin
            push_pix(exp_w, 0);
            push_frame(1, 1'b0, 1'b0);
         end
         for (int j = 0; j < 24; j++) begin
            if (j == 5)        send_bit(vecs[i].hw, 40);
            else if (base_w[j]) send_bit(36, 30);
            else               send_bit(19, 40);
         end
         idle_low(1010);
         if (vecs[i].err) begin
            push_pix(base_w, 0);
            push_frame(1, 1'b0, 1'b0);
            send_word(base_w);
            idle_low(1010);
         end
      end

      // overflow: six words into a five-pixel frame
      for (int k = 0; k < NP; k++) push_pix(24'h100000 + 24'(k), k);
      push_frame(NP, 1'b1, 1'b0);
      for (int k = 0; k < NP + 1; k++) send_word(24'h100000 + 24'(k));
      idle_low(1010);
      check_held("overflow_held", NP, 1'b1, 1'b0);

      // partial: 30 bits
      push_pix(24'h5A5A5A, 0);
      push_frame(1, 1'b0, 1'b1);
      send_word(24'h5A5A5A);
      for (int j = 0; j < 6; j++) send_bit(36, 30);
      idle_low(1010);
      check_held("partial_held", 1, 1'b0, 1'b1);

      // reset in the middle of bit 10
      for (int j = 0; j < 10; j++) begin
         if (rst_w[j]) send_bit(36, 30);
         else          send_bit(19, 40);
      end
      bus.neo_in = 1'b1;
      repeat (10) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_zero("midframe_reset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (25) @(negedge clock);
      bus.neo_in = 1'b0;
      repeat (30) @(negedge clock);
      for (int j = 11; j < 24; j++) begin
         if (rst_w[j]) send_bit(36, 30);
         else          send_bit(19, 40);
      end
      idle_low(1010);
      check_zero("after_truncated_frame");
      push_pix(24'h0F1E2D, 0);
      push_frame(1, 1'b0, 1'b0);
      send_word(24'h0F1E2D);
      idle_low(1010);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL outstanding_events: %0d still queued, required 0 (next kind %0d)",
                  exp_q.size(), exp_q[0].kind);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
